// File: rtl/alu_stream_scoreboard.sv
// In-order scoreboard for the pipelined ALU: golden results queue in a FIFO and are compared with DUT results.
// Optional watchdog enabled by defining ALU_SB_TIMEOUT_EN.
module alu_stream_scoreboard #(
   parameter int          WIDTH        = 32,
   parameter int          DEPTH        = 8,
   parameter int          ID_W         = 8,
   parameter int          CNT_W        = 16,
   parameter logic [3:0]  FLAG_MASK    = 4'hF,
   parameter bit          STOP_ON_FAIL = 1'b1,
   parameter int          TIMEOUT_CYC  = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     exp_valid,
   output logic                     exp_ready,
   input  logic [ID_W-1:0]          exp_id,
   input  logic [WIDTH-1:0]         exp_result,
   input  logic [3:0]               exp_flags,
   input  logic                     act_valid,
   input  logic [WIDTH-1:0]         act_result,
   input  logic [3:0]               act_flags,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         chk_cnt,
   output logic [CNT_W-1:0]         pass_cnt,
   output logic [CNT_W-1:0]         fail_cnt,
   output logic                     mismatch,
   output logic                     underflow,
   output logic                     halted,
   output logic                     first_err_valid,
   output logic [ID_W-1:0]          first_err_id,
   output logic [WIDTH-1:0]         first_err_exp,
   output logic [WIDTH-1:0]         first_err_act,
   output logic                     timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HALT} state_t;

   state_t            state_reg, state_next;
   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [OW-1:0]     occ_reg, occ_next;
   logic [CNT_W-1:0]  chk_cnt_reg, pass_cnt_reg, fail_cnt_reg;
   logic              mismatch_reg, underflow_reg, first_err_valid_reg;
   logic [ID_W-1:0]   first_err_id_reg;
   logic [WIDTH-1:0]  first_err_exp_reg, first_err_act_reg;

   logic [ID_W-1:0]   id_mem  [DEPTH];
   logic [WIDTH-1:0]  res_mem [DEPTH];
   logic [3:0]        flg_mem [DEPTH];

   logic              halted_i, exp_ready_i, full, empty;
   logic              push, pop, uf_ev, match, pass_ev, chk_fail, fail_ev, wd_fire;
   logic [ID_W-1:0]   head_id;
   logic [WIDTH-1:0]  head_res;
   logic [3:0]        head_flags;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
   endfunction

   assign full  = (occ_reg == OW'(DEPTH));
   assign empty = (occ_reg == '0);

   assign head_id    = id_mem[rd_ptr_reg];
   assign head_res   = res_mem[rd_ptr_reg];
   assign head_flags = flg_mem[rd_ptr_reg];

   // No bypass: an act arriving while empty is an underflow even if a push lands this cycle.
   assign push     = exp_valid && exp_ready_i && !clear;
   assign pop      = act_valid && !empty && !halted_i;
   assign uf_ev    = act_valid && empty && !halted_i;
   assign match    = (head_res == act_result) && (((head_flags ^ act_flags) & FLAG_MASK) == 4'h0);
   assign pass_ev  = pop && match;
   assign chk_fail = uf_ev || (pop && !match);
   assign fail_ev  = chk_fail || wd_fire;

   always_comb begin
      occ_next = occ_reg;
      case ({push, pop})
         2'b10:   occ_next = occ_reg + 1'b1;
         2'b01:   occ_next = occ_reg - 1'b1;
         default: occ_next = occ_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         id_mem[wr_ptr_reg]  <= exp_id;
         res_mem[wr_ptr_reg] <= exp_result;
         flg_mem[wr_ptr_reg] <= exp_flags;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // FSM: next state; HALT is sticky until clear or reset
   always_comb begin
      state_next = state_reg;
      if (clear)                         state_next = S_IDLE;
      else if (state_reg == S_HALT)      state_next = S_HALT;
      else if (STOP_ON_FAIL && fail_ev)  state_next = S_HALT;
      else if (occ_next == '0)           state_next = S_IDLE;
      else                               state_next = S_ACTIVE;
   end

   // FSM: outputs
   always_comb begin
      halted_i    = (state_reg == S_HALT);
      exp_ready_i = !full && !halted_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg          <= '0;
         rd_ptr_reg          <= '0;
         occ_reg             <= '0;
         chk_cnt_reg         <= '0;
         pass_cnt_reg        <= '0;
         fail_cnt_reg        <= '0;
         mismatch_reg        <= 1'b0;
         underflow_reg       <= 1'b0;
         first_err_valid_reg <= 1'b0;
         first_err_id_reg    <= '0;
         first_err_exp_reg   <= '0;
         first_err_act_reg   <= '0;
      end else if (clear) begin
         wr_ptr_reg          <= '0;
         rd_ptr_reg          <= '0;
         occ_reg             <= '0;
         chk_cnt_reg         <= '0;
         pass_cnt_reg        <= '0;
         fail_cnt_reg        <= '0;
         mismatch_reg        <= 1'b0;
         underflow_reg       <= 1'b0;
         first_err_valid_reg <= 1'b0;
         first_err_id_reg    <= '0;
         first_err_exp_reg   <= '0;
         first_err_act_reg   <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         occ_reg      <= occ_next;
         chk_cnt_reg  <= sat_inc(chk_cnt_reg, pass_ev || chk_fail);
         pass_cnt_reg <= sat_inc(pass_cnt_reg, pass_ev);
         fail_cnt_reg <= sat_inc(fail_cnt_reg, fail_ev);
         mismatch_reg <= chk_fail;
         if (uf_ev) underflow_reg <= 1'b1;
         // Only the first failing check is captured; later ones leave it intact.
         if (chk_fail && !first_err_valid_reg) begin
            first_err_valid_reg <= 1'b1;
            first_err_id_reg    <= uf_ev ? '0 : head_id;
            first_err_exp_reg   <= uf_ev ? '0 : head_res;
            first_err_act_reg   <= act_result;
         end
      end
   end

`ifdef ALU_SB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_reg;
   logic            timeout_reg;

   // Fires on the TIMEOUT_CYC-th consecutive stalled cycle with entries waiting.
   assign wd_fire = !halted_i && !empty && !pop && !timeout_reg && !clear &&
                    (wd_reg == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_reg      <= '0;
         timeout_reg <= 1'b0;
      end else if (clear) begin
         wd_reg      <= '0;
         timeout_reg <= 1'b0;
      end else begin
         if (empty || pop)                  wd_reg <= '0;
         else if (!halted_i && !timeout_reg) wd_reg <= wd_reg + 1'b1;
         if (wd_fire) timeout_reg <= 1'b1;
      end
   end

   assign timeout = timeout_reg;
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = (TIMEOUT_CYC > 0);
   assign wd_fire = 1'b0;
   assign timeout = 1'b0;
`endif

   assign exp_ready       = exp_ready_i;
   assign halted          = halted_i;
   assign occupancy       = occ_reg;
   assign chk_cnt         = chk_cnt_reg;
   assign pass_cnt        = pass_cnt_reg;
   assign fail_cnt        = fail_cnt_reg;
   assign mismatch        = mismatch_reg;
   assign underflow       = underflow_reg;
   assign first_err_valid = first_err_valid_reg;
   assign first_err_id    = first_err_id_reg;
   assign first_err_exp   = first_err_exp_reg;
   assign first_err_act   = first_err_act_reg;

endmodule
